// File: rtl/weight_fetch_seq.sv
// Read-side sequencer for a registered weight ROM: fetches addresses 0..numWeight-1
// and streams them out through a 2-entry buffer that hides the read latency.

module weight_fetch_seq_chk #(
    parameter int numWeight    = 30,
    parameter int addressWidth = 5
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic [1:0]              occ,
    input logic                    inf,
    input logic                    pop,
    input logic                    mem_ren,
    input logic                    fetch,
    input logic [addressWidth-1:0] mem_radd
);
    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

    a_occ_max:     assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd2);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !((occ == 2'd2) && inf && !pop));
    a_ren_fetch:   assert property (@(posedge clk) disable iff (!rst_n) mem_ren |-> fetch);
    a_radd_range:  assert property (@(posedge clk) disable iff (!rst_n) mem_radd <= LAST_IDX);
endmodule

module weight_fetch_seq #(
    parameter int numWeight    = 30,
    parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_ren,
    output logic [addressWidth-1:0] mem_radd,
    input  logic [dataWidth-1:0]    mem_rdata,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [dataWidth-1:0]    w_data,
    output logic [addressWidth-1:0] w_idx,
    output logic                    w_last
);
    localparam int IA_W = $clog2(numWeight + 1);
    localparam logic [IA_W-1:0]         NUM_W    = IA_W'(numWeight);
    localparam logic [IA_W-1:0]         LAST_IA  = IA_W'(numWeight - 1);
    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

    state_t                  state_r, state_s;
    logic [IA_W-1:0]         ia_r;
    logic [1:0]              occ_r, occ_s;
    logic                    inf_r;
    logic [addressWidth-1:0] inf_idx_r;
    logic [dataWidth-1:0]    head_data_r, tail_data_r;
    logic [addressWidth-1:0] head_idx_r, tail_idx_r;
    logic                    done_r;
    logic                    pop_s, room_s, issue_s, head_wr_s, tail_wr_s;

    assign w_valid  = (occ_r != 2'd0);
    assign w_data   = head_data_r;
    assign w_idx    = head_idx_r;
    assign w_last   = w_valid && (head_idx_r == LAST_IDX);
    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign mem_ren  = issue_s;
    // Once every read is issued the counter sits at numWeight; show the last address instead.
    assign mem_radd = (ia_r < NUM_W) ? ia_r[addressWidth-1:0] : LAST_IDX;

    // Issue decision, buffer write steering and next FSM state.
    always_comb begin
        pop_s     = w_valid & w_ready;
        room_s    = (occ_r + {1'b0, inf_r}) < 2'd2;
        issue_s   = (state_r == FETCH) && (ia_r < NUM_W) && (room_s || pop_s);
        head_wr_s = inf_r && ((occ_r == 2'd0) || ((occ_r == 2'd1) && pop_s));
        tail_wr_s = inf_r && (((occ_r == 2'd1) && !pop_s) || ((occ_r == 2'd2) && pop_s));
        occ_s     = occ_r + {1'b0, inf_r} - {1'b0, pop_s};
        state_s   = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = FETCH;
                else       state_s = IDLE;
            end
            FETCH: begin
                if (issue_s && (ia_r == LAST_IA)) state_s = DRAIN;
                else                              state_s = FETCH;
            end
            DRAIN: begin
                if (pop_s && w_last) state_s = IDLE;
                else                 state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, issue counter and FIFO-ordered output buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ia_r        <= {IA_W{1'b0}};
            occ_r       <= 2'd0;
            inf_r       <= 1'b0;
            inf_idx_r   <= {addressWidth{1'b0}};
            head_data_r <= {dataWidth{1'b0}};
            tail_data_r <= {dataWidth{1'b0}};
            head_idx_r  <= {addressWidth{1'b0}};
            tail_idx_r  <= {addressWidth{1'b0}};
            done_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == DRAIN) && pop_s && w_last;
            inf_r   <= issue_s;
            occ_r   <= occ_s;
            if ((state_r == IDLE) && start) begin
                ia_r <= {IA_W{1'b0}};
            end else if (issue_s) begin
                ia_r <= ia_r + IA_W'(1);
            end
            if (issue_s) begin
                inf_idx_r <= ia_r[addressWidth-1:0];
            end
            if (pop_s && (occ_r == 2'd2)) begin
                head_data_r <= tail_data_r;
                head_idx_r  <= tail_idx_r;
            end else if (head_wr_s) begin
                head_data_r <= mem_rdata;
                head_idx_r  <= inf_idx_r;
            end
            if (tail_wr_s) begin
                tail_data_r <= mem_rdata;
                tail_idx_r  <= inf_idx_r;
            end
        end
    end

    weight_fetch_seq_chk #(
        .numWeight    (numWeight),
        .addressWidth (addressWidth)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .occ      (occ_r),
        .inf      (inf_r),
        .pop      (pop_s),
        .mem_ren  (mem_ren),
        .fetch    (state_r == FETCH),
        .mem_radd (mem_radd)
    );
endmodule

// File: tb/tb_weight_fetch_seq.sv
// Scoreboard bench for weight_fetch_seq: 30-weight instance plus a 1-weight instance,
// each fed by a behavioural registered ROM.

module tb_weight_fetch_seq;
    localparam int NW = 30;
    localparam int AW = 5;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, w_ready;
    logic          busy, done, mem_ren, w_valid, w_last;
    logic [AW-1:0] mem_radd, w_idx;
    logic [DW-1:0] mem_rdata, w_data;

    logic          start1, w_ready1, busy1, done1, mem_ren1, w_valid1, w_last1;
    logic [0:0]    mem_radd1, w_idx1;
    logic [DW-1:0] mem_rdata1, w_data1;

    logic [DW-1:0] rom [NW];
    logic [21:0]   sb_q [$];
    logic [21:0]   exp_v;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_cnt, done_cnt, hs_cnt, last_cnt;
    int first_v_cyc, last_cyc, done_cyc;

    weight_fetch_seq #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_rdata(mem_rdata),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx), .w_last(w_last)
    );

    weight_fetch_seq #(.numWeight(1), .addressWidth(1), .dataWidth(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .mem_ren(mem_ren1), .mem_radd(mem_radd1), .mem_rdata(mem_rdata1),
        .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1), .w_idx(w_idx1), .w_last(w_last1)
    );

    always @(posedge clk) begin
        if (mem_ren)  mem_rdata  <= rom[mem_radd];
        if (mem_ren1) mem_rdata1 <= rom[mem_radd1];
        cyc <= cyc + 1;
    end

    // Output monitor: pops the scoreboard on every handshake and tracks event cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ren) ren_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (w_valid && first_v_cyc < 0) first_v_cyc = cyc;
            checks++;
            if (mem_ren && (!busy || mem_radd > 5'd29)) begin
                errors++;
                $display("FAIL ren_guard: ren with busy=%0b radd=%0d, required busy=1 radd<=29", busy, mem_radd);
            end
            checks++;
            if (dut.occ_r > 2'd2) begin
                errors++;
                $display("FAIL occ_max: occ=%0d, required <=2", dut.occ_r);
            end
            if (w_valid && w_ready) begin
                hs_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: unexpected beat idx=%0d data=%h, required none", w_idx, w_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({w_last, w_idx, w_data} !== exp_v) begin
                        errors++;
                        $display("FAIL sb_beat: got last=%0b idx=%0d data=%h, required last=%0b idx=%0d data=%h",
                                 w_last, w_idx, w_data, exp_v[21], exp_v[20:16], exp_v[15:0]);
                    end
                end
                if (w_last) begin
                    last_cnt++;
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        ren_cnt = 0; done_cnt = 0; hs_cnt = 0; last_cnt = 0;
        first_v_cyc = -1; last_cyc = -1; done_cyc = -1;
    endtask

    task automatic push_pass();
        for (int i = 0; i < NW; i++) sb_q.push_back({(i == NW - 1), 5'(i), rom[i]});
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 500 && done_cnt < target; i++) tick();
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: done count %0d, required %0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, mem_ren, w_valid, w_last, mem_radd, w_data, w_idx} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {busy, done, mem_ren, w_valid, w_last, mem_radd, w_data, w_idx});
        end
        checks++;
        if ({busy1, done1, mem_ren1, w_valid1, w_last1, mem_radd1, w_data1, w_idx1} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs_nw1: got %h, required 0", {busy1, done1, mem_ren1, w_valid1, w_last1, mem_radd1, w_data1, w_idx1});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_burst();
        int s;
        clear_stats();
        w_ready = 1'b1;
        push_pass();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, "burst");
        checks++;
        if (first_v_cyc - s != 3) begin errors++; $display("FAIL burst_first_valid: cycle %0d, required 3", first_v_cyc - s); end
        checks++;
        if (last_cyc - s != 32) begin errors++; $display("FAIL burst_last: cycle %0d, required 32", last_cyc - s); end
        checks++;
        if (done_cyc - s != 33) begin errors++; $display("FAIL burst_done: cycle %0d, required 33", done_cyc - s); end
        checks++;
        if (ren_cnt != 30) begin errors++; $display("FAIL burst_ren: %0d pulses, required 30", ren_cnt); end
        checks++;
        if (hs_cnt != 30 || last_cnt != 1) begin errors++; $display("FAIL burst_beats: %0d beats %0d last, required 30 and 1", hs_cnt, last_cnt); end
        checks++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL burst_end: queue %0d busy %0b, required 0 and 0", sb_q.size(), busy); end
        sb_q.delete();
    endtask

    task automatic test_backpressure();
        int s;
        clear_stats();
        w_ready = 1'b0;
        push_pass();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s + 3) tick();
        for (int c = 3; c <= 12; c++) begin
            checks++;
            if ({w_valid, w_idx, w_data} !== {1'b1, 5'd0, 16'hE88D}) begin
                errors++;
                $display("FAIL bp_hold c%0d: got valid=%0b idx=%0d data=%h, required 1 0 e88d", c, w_valid, w_idx, w_data);
            end
            if (c < 12) tick();
        end
        checks++;
        if (ren_cnt != 2) begin errors++; $display("FAIL bp_ren_stall: %0d pulses, required 2", ren_cnt); end
        tick();
        w_ready = 1'b1;
        wait_done(1, "bp");
        checks++;
        if (hs_cnt != 30 || ren_cnt != 30) begin errors++; $display("FAIL bp_totals: %0d beats %0d reads, required 30 30", hs_cnt, ren_cnt); end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL bp_queue: %0d left, required 0", sb_q.size()); end
        sb_q.delete();
    endtask

    task automatic test_random();
        for (int p = 0; p < 100; p++) begin
            clear_stats();
            push_pass();
            start = 1'b1;
            w_ready = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            for (int i = 0; i < 400 && done_cnt == 0; i++) begin
                w_ready = 1'($urandom_range(0, 1));
                tick();
            end
            checks++;
            if (done_cnt != 1 || sb_q.size() != 0 || hs_cnt != 30) begin
                errors++;
                $display("FAIL rand_pass %0d: done %0d left %0d beats %0d, required 1 0 30", p, done_cnt, sb_q.size(), hs_cnt);
            end
            sb_q.delete();
        end
        w_ready = 1'b1;
    endtask

    task automatic test_start_edges();
        int s, s2;
        clear_stats();
        w_ready = 1'b1;
        push_pass();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s + 10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s + 33) tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL edge_done_cycle: done=%0b, required 1", done); end
        first_v_cyc = -1;
        push_pass();
        s2 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2, "edge");
        checks++;
        if (first_v_cyc - s2 != 3) begin errors++; $display("FAIL edge_restart_latency: %0d, required 3", first_v_cyc - s2); end
        checks++;
        if (ren_cnt != 60 || hs_cnt != 60) begin errors++; $display("FAIL edge_totals: %0d reads %0d beats, required 60 60", ren_cnt, hs_cnt); end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL edge_queue: %0d left, required 0", sb_q.size()); end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        int s;
        clear_stats();
        w_ready = 1'b1;
        push_pass();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s + 15) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, mem_ren, w_valid, w_last, mem_radd, w_data, w_idx} !== 31'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, required 0", {busy, done, mem_ren, w_valid, w_last, mem_radd, w_data, w_idx});
        end
        rst_n = 1'b1;
        sb_q.delete();
        clear_stats();
        tick();
        push_pass();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, "midreset");
        checks++;
        if (first_v_cyc - s != 3 || hs_cnt != 30 || ren_cnt != 30) begin
            errors++;
            $display("FAIL midreset_restart: latency %0d beats %0d reads %0d, required 3 30 30", first_v_cyc - s, hs_cnt, ren_cnt);
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL midreset_queue: %0d left, required 0", sb_q.size()); end
        sb_q.delete();
    endtask

    task automatic test_single();
        int v_cyc, d_cyc, ren1, vcnt;
        v_cyc = -1; d_cyc = -1; ren1 = 0; vcnt = 0;
        w_ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (mem_radd1 !== 1'b0) begin errors++; $display("FAIL nw1_radd c%0d: got %0d, required 0", c, mem_radd1); end
            if (mem_ren1) ren1++;
            if (w_valid1) begin
                vcnt++;
                if (v_cyc < 0) v_cyc = c;
                checks++;
                if ({w_last1, w_idx1, w_data1} !== {1'b1, 1'b0, rom[0]}) begin
                    errors++;
                    $display("FAIL nw1_beat: got last=%0b idx=%0d data=%h, required 1 0 %h", w_last1, w_idx1, w_data1, rom[0]);
                end
            end
            if (done1) d_cyc = c;
            tick();
        end
        checks++;
        if (v_cyc != 3 || vcnt != 1) begin errors++; $display("FAIL nw1_valid: cycle %0d count %0d, required 3 1", v_cyc, vcnt); end
        checks++;
        if (d_cyc != 4) begin errors++; $display("FAIL nw1_done: cycle %0d, required 4", d_cyc); end
        checks++;
        if (ren1 != 1 || busy1 !== 1'b0) begin errors++; $display("FAIL nw1_ren: %0d reads busy %0b, required 1 0", ren1, busy1); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NW; i++) rom[i] = 16'hE88D + 16'(i * 18);
        rom[NW - 1] = 16'hEAA6;
        rst_n = 1'b0; start = 1'b0; w_ready = 1'b1;
        start1 = 1'b0; w_ready1 = 1'b1;
        clear_stats();
        @(posedge clk);
        #1;
        test_reset();
        test_burst();
        test_backpressure();
        test_random();
        test_start_edges();
        test_reset_mid();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
